mix_frame_scheduler: RTL and testbench

MIX_FRAME_SCHEDULER -- requirements
Module: mix_frame_scheduler

---
 rtl/mix_frame_scheduler.sv | 160 ++++++++++++++++
 tb/tb_mix_frame_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_frame_scheduler.sv
// rtl/mix_frame_scheduler.sv - audio frame divider and voice/mix/present sequencer with DAC sample handshake
// Optional mute input enabled by defining MIX_FRAME_SCHEDULER_MUTE_EN.
`timescale 1ns/1ps

module mix_frame_scheduler #(
    parameter int FRAME_DIV   = 1134,
    parameter int MIX_LATENCY = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        voice_tick,
    output logic        mix_start,
    input  logic [17:0] mix_right,
    input  logic [17:0] mix_left,
    output logic [17:0] dac_right,
    output logic [17:0] dac_left,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun,
    input  logic        overrun_clr,
`ifdef MIX_FRAME_SCHEDULER_MUTE_EN
    input  logic        mute,
`endif
    output logic [15:0] frame_count
);

    localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);
    localparam logic [15:0] LAT_LOAD = 16'(MIX_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VOICE,
        S_MIX,
        S_WAIT,
        S_PRESENT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] wait_q, wait_d;
    logic        voice_tick_q, voice_tick_d;
    logic        mix_start_q, mix_start_d;
    logic        valid_q, valid_d;
    logic [17:0] dac_right_q, dac_right_d;
    logic [17:0] dac_left_q, dac_left_d;
    logic        overrun_q, overrun_d;
    logic [15:0] frame_q, frame_d;

    logic        tick;
    logic        drop;
    logic [17:0] cap_right;
    logic [17:0] cap_left;

    // Frame divider: parked at zero while disabled so re-enabling restarts a full frame.
    always_comb begin
        tick  = enable && (div_q == DIV_LAST);
        div_d = 16'd0;
        if (enable && (div_q != DIV_LAST)) begin
            div_d = div_q + 16'd1;
        end
    end

    always_comb begin
        cap_right = mix_right;
        cap_left  = mix_left;
`ifdef MIX_FRAME_SCHEDULER_MUTE_EN
        if (mute) begin
            cap_right = 18'd0;
            cap_left  = 18'd0;
        end
`endif
    end

    // A tick that lands on a busy sequencer is lost; the sequence itself keeps going.
    assign drop      = tick && (state_q != S_IDLE);
    assign overrun_d = (overrun_q && !overrun_clr) || drop;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        voice_tick_d = 1'b0;
        mix_start_d  = 1'b0;
        valid_d      = valid_q;
        dac_right_d  = dac_right_q;
        dac_left_d   = dac_left_q;
        frame_d      = frame_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    voice_tick_d = 1'b1;
                    state_d      = S_VOICE;
                end
            end
            S_VOICE: begin
                mix_start_d = 1'b1;
                state_d     = S_MIX;
            end
            S_MIX: begin
                wait_d  = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q - 16'd1;
                if (wait_q <= 16'd1) begin
                    wait_d      = 16'd0;
                    dac_right_d = cap_right;
                    dac_left_d  = cap_left;
                    valid_d     = 1'b1;
                    state_d     = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (valid_q && sample_ready) begin
                    valid_d = 1'b0;
                    frame_d = frame_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_q        <= 16'd0;
            wait_q       <= 16'd0;
            voice_tick_q <= 1'b0;
            mix_start_q  <= 1'b0;
            valid_q      <= 1'b0;
            dac_right_q  <= 18'd0;
            dac_left_q   <= 18'd0;
            overrun_q    <= 1'b0;
            frame_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            wait_q       <= wait_d;
            voice_tick_q <= voice_tick_d;
            mix_start_q  <= mix_start_d;
            valid_q      <= valid_d;
            dac_right_q  <= dac_right_d;
            dac_left_q   <= dac_left_d;
            overrun_q    <= overrun_d;
            frame_q      <= frame_d;
        end
    end

    assign voice_tick   = voice_tick_q;
    assign mix_start    = mix_start_q;
    assign sample_valid = valid_q;
    assign dac_right    = dac_right_q;
    assign dac_left     = dac_left_q;
    assign overrun      = overrun_q;
    assign frame_count  = frame_q;

endmodule

// File: tb/tb_mix_frame_scheduler.sv
// tb/tb_mix_frame_scheduler.sv - self-checking bench for mix_frame_scheduler
`timescale 1ns/1ps

module tb_mix_frame_scheduler;

    localparam int FD  = 20;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sample_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [17:0] mix_right = 18'd0;
    logic [17:0] mix_left = 18'd0;
`ifdef MIX_FRAME_SCHEDULER_MUTE_EN
    logic        mute = 1'b0;
`endif
    logic        voice_tick;
    logic        mix_start;
    logic        sample_valid;
    logic        overrun;
    logic [17:0] dac_right;
    logic [17:0] dac_left;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    mix_frame_scheduler #(.FRAME_DIV(FD), .MIX_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .voice_tick   (voice_tick),
        .mix_start    (mix_start),
        .mix_right    (mix_right),
        .mix_left     (mix_left),
        .dac_right    (dac_right),
        .dac_left     (dac_left),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
`ifdef MIX_FRAME_SCHEDULER_MUTE_EN
        .mute         (mute),
`endif
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [17:0] mr;
        logic [17:0] ml;
        int          hold;
        bit          early;
        logic [17:0] er;
        logic [17:0] el;
    } vec_t;

    vec_t tbl[5];

    // Reference model: a frame in flight is tracked by its age in cycles since the tick.
    int          m_div;
    bit          m_active;
    int          m_age;
    bit          m_valid;
    logic [17:0] m_dr, m_dl;
    bit          m_ov;
    logic [15:0] m_fc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_voice(input int bound);
        int n;
        n = 0;
        while (!voice_tick && n < bound) begin
            step();
            n++;
        end
        if (!voice_tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL voice_timeout: no voice_tick within %0d cycles", bound);
        end
    endtask

    function automatic logic [55:0] all_outs();
        return {voice_tick, mix_start, sample_valid, overrun, dac_right, dac_left, frame_count};
    endfunction

    task automatic model_step(input bit r, input bit en, input bit rdy, input bit clr,
                              input logic [17:0] mr, input logic [17:0] ml, input bit mu);
        bit tk;
        if (r) begin
            m_div = 0; m_active = 0; m_age = 0; m_valid = 0;
            m_dr = 0; m_dl = 0; m_ov = 0; m_fc = 0;
            return;
        end
        tk    = en && (m_div == FD - 1);
        m_div = en ? (m_div + 1) % FD : 0;
        m_ov  = (m_ov && !clr) || (tk && m_active);
        if (m_active) begin
            if (m_valid) begin
                if (rdy) begin
                    m_valid  = 0;
                    m_fc     = m_fc + 16'd1;
                    m_active = 0;
                end
            end else begin
                m_age++;
                if (m_age == LAT + 3) begin
                    m_valid = 1;
                    m_dr    = mu ? 18'd0 : mr;
                    m_dl    = mu ? 18'd0 : ml;
                end
            end
        end else if (tk) begin
            m_active = 1;
            m_age    = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, lat, prev_voice, vt, ms, nv;
        bit stable;
        logic [15:0] fc;
        bit r, en, rdy, clr, mu;
        logic [17:0] mr, ml;
        logic [55:0] expv;
        bit slow;

        tbl[0] = '{18'h1FFFF, 18'h20000, 6, 1'b0, 18'h1FFFF, 18'h20000};
        tbl[1] = '{18'h00000, 18'h3FFFF, 0, 1'b0, 18'h00000, 18'h3FFFF};
        tbl[2] = '{18'h15555, 18'h2AAAA, 3, 1'b0, 18'h15555, 18'h2AAAA};
        tbl[3] = '{18'h00123, 18'h00456, 0, 1'b1, 18'h00123, 18'h00456};
        tbl[4] = '{18'h3FFFF, 18'h00001, 1, 1'b0, 18'h3FFFF, 18'h00001};

        repeat (3) step();
        chk("reset_state", all_outs(), 56'd0);

        // First voice_tick comes one frame after enable is raised.
        rst = 1'b0;
        enable = 1'b1;
        n = 0;
        while (!voice_tick && n < 60) begin
            step();
            n++;
        end
        chk("first_tick_latency", n, FD);

        prev_voice = -1;
        for (int i = 0; i < 5; i++) begin
            wait_voice(60);
            if (prev_voice >= 0) chk("voice_period", cyc - prev_voice, FD);
            prev_voice = cyc;
            mix_right = tbl[i].mr;
            mix_left = tbl[i].ml;
            sample_ready = tbl[i].early;
            step();
            chk("mix_start_after_voice", mix_start, 1);
            lat = 1;
            while (!sample_valid && lat < 30) begin
                step();
                lat++;
            end
            chk("valid_latency", lat, LAT + 2);
            chk("dac_capture", {dac_right, dac_left}, {tbl[i].er, tbl[i].el});
            mix_right = ~tbl[i].mr;
            mix_left = ~tbl[i].ml;
            fc = frame_count;
            stable = 1'b1;
            for (int h = 0; h < tbl[i].hold; h++) begin
                step();
                if ({dac_right, dac_left} !== {tbl[i].er, tbl[i].el} || !sample_valid) stable = 1'b0;
            end
            chk("dac_hold", stable, 1);
            sample_ready = 1'b1;
            step();
            chk("valid_drop", sample_valid, 0);
            chk("frame_count_inc", frame_count, fc + 16'd1);
            sample_ready = 1'b0;
        end
        chk("frame_count_5", frame_count, 5);

        // Slow consumer: next tick must be dropped without a second sequence.
        wait_voice(60);
        sample_ready = 1'b0;
        vt = 1;
        ms = 0;
        for (int i = 0; i < 26; i++) begin
            step();
            vt += int'(voice_tick);
            ms += int'(mix_start);
        end
        sample_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            vt += int'(voice_tick);
            ms += int'(mix_start);
        end
        chk("overrun_set", overrun, 1);
        chk("voice_ticks_in_window", vt, 1);
        chk("mix_starts_in_window", ms, 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Clear coinciding with a dropped tick.
        wait_voice(60);
        sample_ready = 1'b0;
        repeat (19) step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("overrun_set_wins", overrun, 1);
        sample_ready = 1'b1;

        // Disabling mid-sequence lets the frame finish and starts nothing new.
        wait_voice(60);
        enable = 1'b0;
        lat = 0;
        while (!sample_valid && lat < 30) begin
            step();
            lat++;
        end
        chk("valid_after_disable", lat, LAT + 2);
        vt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            vt += int'(voice_tick);
        end
        chk("no_tick_while_disabled", vt, 0);
        chk("valid_done_disabled", sample_valid, 0);

        // Reset during WAIT discards the pending sample.
        enable = 1'b1;
        wait_voice(60);
        sample_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("outputs_in_rst", all_outs(), 56'd0);
        step();
        chk("outputs_in_rst_edge", all_outs(), 56'd0);
        rst = 1'b0;
        n = 0;
        nv = 0;
        while (!voice_tick && n < 60) begin
            step();
            n++;
            nv += int'(sample_valid);
        end
        chk("no_valid_after_rst", nv, 0);
        chk("tick_after_rst", n, FD);

`ifdef MIX_FRAME_SCHEDULER_MUTE_EN
        mute = 1'b1;
        mix_right = 18'h00123;
        mix_left = 18'h00456;
        lat = 0;
        while (!sample_valid && lat < 30) begin
            step();
            lat++;
        end
        chk("mute_dac_right", dac_right, 0);
        chk("mute_dac_left", dac_left, 0);
        fc = frame_count;
        sample_ready = 1'b1;
        step();
        chk("mute_frame_count", frame_count, fc + 16'd1);
        sample_ready = 1'b0;
        mute = 1'b0;
`endif

        // Random traffic against the reference model.
        en = 1'b1;
        slow = 1'b0;
        mu = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) slow = ($urandom_range(0, 2) == 0);
            r = (i == 0) || ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 149) == 0) en = !en;
            rdy = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            mr = 18'($urandom);
            ml = 18'($urandom);
`ifdef MIX_FRAME_SCHEDULER_MUTE_EN
            mu = ($urandom_range(0, 3) == 0);
            mute = mu;
`endif
            rst = r;
            enable = en;
            sample_ready = rdy;
            overrun_clr = clr;
            mix_right = mr;
            mix_left = ml;
            step();
            model_step(r, en, rdy, clr, mr, ml, mu);
            expv = {m_active && m_age == 1, m_active && m_age == 2, m_valid, m_ov, m_dr, m_dl, m_fc};
            chk($sformatf("random_cycle_%0d", i), all_outs(), expv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
